// File: rtl/mm_pkg.sv
// Shared MasterMind types: FSM state encoding, peg colour, history record and LFSR taps.
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GEN        = 3'd1,
    S_INPUT      = 3'd2,
    S_EVAL_EXACT = 3'd3,
    S_EVAL_COLOR = 3'd4,
    S_COMMIT     = 3'd5,
    S_WIN        = 3'd6,
    S_LOSE       = 3'd7
  } e_MM_STATE;

  typedef logic [2:0] t_PEG;

  localparam int MAX_PEGS = 4;

  typedef struct packed {
    logic [2:0]            blows;
    logic [2:0]            hits;
    t_PEG [MAX_PEGS-1:0]   guess;
  } st_HIST_ENTRY;

  // Record consumed by the VGA renderer and segment display.
  typedef struct packed {
    e_MM_STATE  state;
    logic [1:0] sel;
    logic [3:0] round;
    logic [2:0] hits;
    logic [2:0] blows;
  } st_GAME_STATE;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mm_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the secret-code colour source.
module mm_lfsr16 import mm_pkg::*; #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] Q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/mastermind_round_controller.sv
// MasterMind game sequencer: secret generation, guess entry, iterative hit/blow
// scoring and per-round history write-back.
module mastermind_round_controller import mm_pkg::*; #(
  parameter int          PEGS       = 4,
  parameter int          COLORS     = 6,
  parameter int          MAX_ROUNDS = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BTN_NEXT,
  input  logic                 BTN_INC,
  input  logic                 BTN_OK,
  input  logic                 CODE_LOAD,
  input  logic [PEGS*3-1:0]    CODE_IN,
  output logic [2:0]           STATE,
  output logic [1:0]           SEL,
  output logic [PEGS*3-1:0]    GUESS,
  output logic [3:0]           ROUND,
  output logic [2:0]           HITS,
  output logic [2:0]           BLOWS,
  output logic                 HIST_WE,
  output logic [3:0]           HIST_ADDR,
  output logic [PEGS*3+5:0]    HIST_DATA,
  output logic                 BUSY
);

  localparam logic [1:0] LAST_IDX  = 2'(PEGS - 1);
  localparam logic [2:0] MAX_SCORE = 3'(PEGS);

  e_MM_STATE              r_state, w_state_next;
  logic [1:0]             r_sel, w_sel_next;
  t_PEG [PEGS-1:0]        r_guess, w_guess_next;
  t_PEG [PEGS-1:0]        r_secret, w_secret_next;
  logic [3:0]             r_round, w_round_next;
  logic [2:0]             r_hits, w_hits_next;
  logic [2:0]             r_blows, w_blows_next;
  logic [2:0]             r_hit_cnt, w_hit_cnt_next;
  logic [2:0]             r_blow_cnt, w_blow_cnt_next;
  logic [PEGS-1:0]        r_gmatch, w_gmatch_next;
  logic [PEGS-1:0]        r_smatch, w_smatch_next;
  logic [1:0]             r_i, w_i_next;
  logic [1:0]             r_j, w_j_next;
  logic                   r_hist_we, w_hist_we_next;
  logic [3:0]             r_hist_addr, w_hist_addr_next;
  logic [PEGS*3+5:0]      r_hist_data, w_hist_data_next;

  logic [15:0]            w_lfsr;
  logic                   w_lfsr_unused;
  logic                   w_rand_ok;

  mm_lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .Q   (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:3];
  assign w_rand_ok     = ({1'b0, w_lfsr[2:0]} < 4'(COLORS));

  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_guess_next     = r_guess;
    w_secret_next    = r_secret;
    w_round_next     = r_round;
    w_hits_next      = r_hits;
    w_blows_next     = r_blows;
    w_hit_cnt_next   = r_hit_cnt;
    w_blow_cnt_next  = r_blow_cnt;
    w_gmatch_next    = r_gmatch;
    w_smatch_next    = r_smatch;
    w_i_next         = r_i;
    w_j_next         = r_j;
    w_hist_we_next   = 1'b0;
    w_hist_addr_next = r_hist_addr;
    w_hist_data_next = r_hist_data;

    case (r_state)
      S_IDLE: begin
        if (CODE_LOAD || BTN_OK) begin
          w_round_next = '0;
          w_sel_next   = '0;
          w_guess_next = '0;
          w_hits_next  = '0;
          w_blows_next = '0;
          w_i_next     = '0;
          if (CODE_LOAD) begin
            w_secret_next = CODE_IN;
            w_state_next  = S_INPUT;
          end else begin
            w_state_next  = S_GEN;
          end
        end
      end

      S_GEN: begin
        // Out-of-range LFSR values are discarded so colours stay uniform.
        if (w_rand_ok) begin
          w_secret_next[r_i] = t_PEG'(w_lfsr[2:0]);
          w_i_next           = r_i + 2'd1;
          if (r_i == LAST_IDX) begin
            w_state_next = S_INPUT;
          end
        end
      end

      S_INPUT: begin
        if (CODE_LOAD) begin
          w_secret_next = CODE_IN;
        end else if (BTN_OK) begin
          w_state_next    = S_EVAL_EXACT;
          w_i_next        = '0;
          w_gmatch_next   = '0;
          w_smatch_next   = '0;
          w_hit_cnt_next  = '0;
          w_blow_cnt_next = '0;
        end else if (BTN_INC) begin
          w_guess_next[r_sel] = (r_guess[r_sel] == t_PEG'(COLORS - 1)) ? t_PEG'(0)
                                                                       : r_guess[r_sel] + t_PEG'(1);
        end else if (BTN_NEXT) begin
          w_sel_next = (r_sel == LAST_IDX) ? 2'd0 : r_sel + 2'd1;
        end
      end

      S_EVAL_EXACT: begin
        if (r_guess[r_i] == r_secret[r_i]) begin
          w_gmatch_next[r_i] = 1'b1;
          w_smatch_next[r_i] = 1'b1;
          if (r_hit_cnt < MAX_SCORE) w_hit_cnt_next = r_hit_cnt + 3'd1;
        end
        if (r_i == LAST_IDX) begin
          w_state_next = S_EVAL_COLOR;
          w_i_next     = '0;
          w_j_next     = '0;
        end else begin
          w_i_next = r_i + 2'd1;
        end
      end

      S_EVAL_COLOR: begin
        if (!r_gmatch[r_i] && !r_smatch[r_j] && (r_guess[r_i] == r_secret[r_j])) begin
          w_gmatch_next[r_i] = 1'b1;
          w_smatch_next[r_j] = 1'b1;
          if (r_blow_cnt < MAX_SCORE) w_blow_cnt_next = r_blow_cnt + 3'd1;
        end
        if (r_j == LAST_IDX) begin
          w_j_next = '0;
          if (r_i == LAST_IDX) begin
            // Final scores are registered on entry so they line up with HIST_WE.
            w_state_next     = S_COMMIT;
            w_hist_we_next   = 1'b1;
            w_hist_addr_next = r_round;
            w_hist_data_next = {w_blow_cnt_next, r_hit_cnt, r_guess};
            w_hits_next      = r_hit_cnt;
            w_blows_next     = w_blow_cnt_next;
          end else begin
            w_i_next = r_i + 2'd1;
          end
        end else begin
          w_j_next = r_j + 2'd1;
        end
      end

      S_COMMIT: begin
        if (r_hit_cnt == MAX_SCORE) begin
          w_state_next = S_WIN;
        end else if (r_round == 4'(MAX_ROUNDS - 1)) begin
          w_state_next = S_LOSE;
        end else begin
          w_state_next = S_INPUT;
          w_round_next = r_round + 4'd1;
        end
      end

      S_WIN, S_LOSE: begin
        if (BTN_OK) w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_guess     <= '0;
      r_secret    <= '0;
      r_round     <= '0;
      r_hits      <= '0;
      r_blows     <= '0;
      r_hit_cnt   <= '0;
      r_blow_cnt  <= '0;
      r_gmatch    <= '0;
      r_smatch    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_hist_we   <= 1'b0;
      r_hist_addr <= '0;
      r_hist_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_guess     <= w_guess_next;
      r_secret    <= w_secret_next;
      r_round     <= w_round_next;
      r_hits      <= w_hits_next;
      r_blows     <= w_blows_next;
      r_hit_cnt   <= w_hit_cnt_next;
      r_blow_cnt  <= w_blow_cnt_next;
      r_gmatch    <= w_gmatch_next;
      r_smatch    <= w_smatch_next;
      r_i         <= w_i_next;
      r_j         <= w_j_next;
      r_hist_we   <= w_hist_we_next;
      r_hist_addr <= w_hist_addr_next;
      r_hist_data <= w_hist_data_next;
    end
  end

  assign STATE     = r_state;
  assign SEL       = r_sel;
  assign GUESS     = r_guess;
  assign ROUND     = r_round;
  assign HITS      = r_hits;
  assign BLOWS     = r_blows;
  assign HIST_WE   = r_hist_we;
  assign HIST_ADDR = r_hist_addr;
  assign HIST_DATA = r_hist_data;
  assign BUSY      = (r_state == S_GEN) || (r_state == S_EVAL_EXACT) ||
                     (r_state == S_EVAL_COLOR) || (r_state == S_COMMIT);

endmodule

// File: tb/tb_mastermind_round_controller.sv
// Directed bench for the MasterMind round controller with hand-computed scores.
module tb_mastermind_round_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        BTN_NEXT = 1'b0;
  logic        BTN_INC = 1'b0;
  logic        BTN_OK = 1'b0;
  logic        CODE_LOAD = 1'b0;
  logic [11:0] CODE_IN = '0;
  logic [2:0]  STATE;
  logic [1:0]  SEL;
  logic [11:0] GUESS;
  logic [3:0]  ROUND;
  logic [2:0]  HITS;
  logic [2:0]  BLOWS;
  logic        HIST_WE;
  logic [3:0]  HIST_ADDR;
  logic [17:0] HIST_DATA;
  logic        BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int bad_we   = 0;

  mastermind_round_controller dut (
    .CLK(CLK), .RST(RST), .BTN_NEXT(BTN_NEXT), .BTN_INC(BTN_INC), .BTN_OK(BTN_OK),
    .CODE_LOAD(CODE_LOAD), .CODE_IN(CODE_IN), .STATE(STATE), .SEL(SEL), .GUESS(GUESS),
    .ROUND(ROUND), .HITS(HITS), .BLOWS(BLOWS), .HIST_WE(HIST_WE), .HIST_ADDR(HIST_ADDR),
    .HIST_DATA(HIST_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (HIST_WE === 1'b1 && STATE !== 3'd5) bad_we++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse(input bit ok, input bit inc, input bit nxt);
    BTN_OK = ok; BTN_INC = inc; BTN_NEXT = nxt;
    @(negedge CLK);
    BTN_OK = 1'b0; BTN_INC = 1'b0; BTN_NEXT = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic load_code(input logic [11:0] c);
    CODE_LOAD = 1'b1; CODE_IN = c;
    @(negedge CLK);
    CODE_LOAD = 1'b0;
  endtask

  // Walks SEL from 0 over every peg; leaves SEL back at 0.
  task automatic set_guess(input logic [11:0] from, input logic [11:0] to);
    for (int p = 0; p < 4; p++) begin
      int a, b, n;
      a = int'(from[3*p +: 3]);
      b = int'(to[3*p +: 3]);
      n = (b - a + 6) % 6;
      repeat (n) pulse(0, 1, 0);
      pulse(0, 0, 1);
    end
  endtask

  // Latency counts cycles from the OK cycle to the HIST_WE cycle; returns one cycle after commit.
  task automatic submit(output int lat, output logic [3:0] addr, output logic [17:0] data);
    pulse(1, 0, 0);
    lat = 1;
    while (HIST_WE !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    addr = HIST_ADDR;
    data = HIST_DATA;
    $display("commit: lat=%0d addr=%0d data=%h", lat, addr, data);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if ({STATE, SEL, GUESS, ROUND, HITS, BLOWS} !== '0)
      $display("FAIL reset_fields: got st=%0d sel=%0d g=%h r=%0d h=%0d b=%0d want all 0", STATE, SEL, GUESS, ROUND, HITS, BLOWS);
    else n_pass++;
    n_checks++;
    if ({HIST_WE, HIST_ADDR, HIST_DATA, BUSY} !== '0)
      $display("FAIL reset_hist: got we=%0d addr=%0d data=%h busy=%0d want 0", HIST_WE, HIST_ADDR, HIST_DATA, BUSY);
    else n_pass++;
  endtask

  task automatic test_gen();
    int n, lat, total;
    logic [3:0] addr;
    logic [17:0] data;
    logic [2:0] cv, pv;
    pulse(1, 0, 0);
    n_checks++;
    if (STATE !== 3'd1 || BUSY !== 1'b1) $display("FAIL gen_enter: got st=%0d busy=%0d want 1/1", STATE, BUSY);
    else n_pass++;
    n = 0;
    while (STATE !== 3'd2 && n < 32) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (STATE !== 3'd2 || BUSY !== 1'b0) $display("FAIL gen_done: got st=%0d busy=%0d after %0d want 2/0", STATE, BUSY, n);
    else n_pass++;
    // Guessing all-c for each legal colour: hits sum to PEGS only if every secret peg is < 6.
    total = 0;
    for (int c = 0; c < 6; c++) begin
      if (STATE !== 3'd2) break;
      cv = c[2:0];
      pv = cv - 3'd1;
      if (c > 0) set_guess({4{pv}}, {4{cv}});
      submit(lat, addr, data);
      n_checks++;
      if (addr !== c[3:0] || BLOWS !== 3'd0)
        $display("FAIL gen_probe%0d: got addr=%0d blows=%0d want %0d/0", c, addr, BLOWS, c);
      else n_pass++;
      total += int'(HITS);
    end
    n_checks++;
    if (total !== 4) $display("FAIL gen_colour_range: got hit sum %0d want 4", total);
    else n_pass++;
  endtask

  task automatic test_exact_win();
    int lat;
    logic [3:0] addr;
    logic [17:0] data;
    logic [11:0] g;
    g = {3'd4, 3'd3, 3'd2, 3'd1};
    do_reset(2);
    load_code(g);
    n_checks++;
    if (STATE !== 3'd2 || ROUND !== 4'd0) $display("FAIL win_load: got st=%0d round=%0d want 2/0", STATE, ROUND);
    else n_pass++;
    set_guess(12'h000, g);
    n_checks++;
    if (GUESS !== g || SEL !== 2'd0) $display("FAIL win_guess: got %h sel=%0d want %h sel=0", GUESS, SEL, g);
    else n_pass++;
    submit(lat, addr, data);
    n_checks++;
    if (lat !== 21) $display("FAIL win_latency: got %0d want 21", lat);
    else n_pass++;
    n_checks++;
    if (addr !== 4'd0 || data !== {3'd0, 3'd4, g}) $display("FAIL win_hist: got addr=%0d data=%h want 0/%h", addr, data, {3'd0, 3'd4, g});
    else n_pass++;
    n_checks++;
    if (HITS !== 3'd4 || BLOWS !== 3'd0 || STATE !== 3'd6 || HIST_WE !== 1'b0)
      $display("FAIL win_result: got h=%0d b=%0d st=%0d we=%0d want 4/0/6/0", HITS, BLOWS, STATE, HIST_WE);
    else n_pass++;
    pulse(1, 0, 0);
    n_checks++;
    if (STATE !== 3'd0) $display("FAIL win_ack: got st=%0d want 0", STATE);
    else n_pass++;
  endtask

  task automatic test_duplicates();
    int lat;
    logic [3:0] addr;
    logic [17:0] data;
    logic [11:0] s, g;
    s = {3'd3, 3'd2, 3'd1, 3'd1};
    g = {3'd1, 3'd1, 3'd2, 3'd1};
    load_code(s);
    set_guess(12'h000, g);
    submit(lat, addr, data);
    n_checks++;
    if (HITS !== 3'd1 || BLOWS !== 3'd2) $display("FAIL dup_score: got h=%0d b=%0d want 1/2", HITS, BLOWS);
    else n_pass++;
    n_checks++;
    if (STATE !== 3'd2 || ROUND !== 4'd1 || data !== {3'd2, 3'd1, g})
      $display("FAIL dup_next: got st=%0d round=%0d data=%h want 2/1/%h", STATE, ROUND, data, {3'd2, 3'd1, g});
    else n_pass++;
    // CODE_LOAD in INPUT swaps the secret and masks a coincident INC.
    CODE_LOAD = 1'b1; CODE_IN = g; BTN_INC = 1'b1;
    @(negedge CLK);
    CODE_LOAD = 1'b0; BTN_INC = 1'b0;
    n_checks++;
    if (GUESS !== g || STATE !== 3'd2) $display("FAIL load_priority: got g=%h st=%0d want %h/2", GUESS, STATE, g);
    else n_pass++;
    submit(lat, addr, data);
    n_checks++;
    if (HITS !== 3'd4 || STATE !== 3'd6 || addr !== 4'd1)
      $display("FAIL load_input_win: got h=%0d st=%0d addr=%0d want 4/6/1", HITS, STATE, addr);
    else n_pass++;
    pulse(1, 0, 0);
  endtask

  task automatic test_loss();
    int lat;
    logic [3:0] addr;
    logic [17:0] data;
    logic [2:0] five;
    five = 3'd5;
    do_reset(2);
    load_code({4{five}});
    for (int r = 0; r < 10; r++) begin
      submit(lat, addr, data);
      n_checks++;
      if (addr !== r[3:0] || data !== 18'd0) $display("FAIL loss_hist%0d: got addr=%0d data=%h want %0d/0", r, addr, data, r);
      else n_pass++;
      if (r < 9) begin
        n_checks++;
        if (STATE !== 3'd2 || ROUND !== 4'(r + 1)) $display("FAIL loss_round%0d: got st=%0d round=%0d want 2/%0d", r, STATE, ROUND, r + 1);
        else n_pass++;
      end
    end
    n_checks++;
    if (STATE !== 3'd7) $display("FAIL loss_state: got %0d want 7", STATE);
    else n_pass++;
    pulse(1, 0, 0);
    n_checks++;
    if (STATE !== 3'd0) $display("FAIL loss_ack: got %0d want 0", STATE);
    else n_pass++;
  endtask

  task automatic test_input_wrap();
    int n;
    load_code(12'h000);
    repeat (5) pulse(0, 1, 0);
    n_checks++;
    if (GUESS !== 12'd5) $display("FAIL inc_top: got %h want 005", GUESS);
    else n_pass++;
    pulse(0, 1, 0);
    n_checks++;
    if (GUESS !== 12'd0) $display("FAIL inc_wrap: got %h want 000", GUESS);
    else n_pass++;
    repeat (3) pulse(0, 0, 1);
    n_checks++;
    if (SEL !== 2'd3) $display("FAIL sel_top: got %0d want 3", SEL);
    else n_pass++;
    pulse(0, 0, 1);
    n_checks++;
    if (SEL !== 2'd0) $display("FAIL sel_wrap: got %0d want 0", SEL);
    else n_pass++;
    pulse(0, 1, 1);
    n_checks++;
    if (GUESS !== 12'd1 || SEL !== 2'd0) $display("FAIL inc_over_next: got g=%h sel=%0d want 001/0", GUESS, SEL);
    else n_pass++;
    pulse(1, 1, 0);
    n_checks++;
    if (STATE !== 3'd3 || GUESS !== 12'd1) $display("FAIL ok_over_inc: got st=%0d g=%h want 3/001", STATE, GUESS);
    else n_pass++;
    pulse(0, 1, 1);
    n_checks++;
    if (GUESS !== 12'd1 || SEL !== 2'd0 || BUSY !== 1'b1) $display("FAIL busy_ignore: got g=%h sel=%0d busy=%0d want 001/0/1", GUESS, SEL, BUSY);
    else n_pass++;
    n = 0;
    while (HIST_WE !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    n_checks++;
    if (HITS !== 3'd3 || BLOWS !== 3'd0 || STATE !== 3'd2 || ROUND !== 4'd1)
      $display("FAIL wrap_score: got h=%0d b=%0d st=%0d r=%0d want 3/0/2/1", HITS, BLOWS, STATE, ROUND);
    else n_pass++;
  endtask

  task automatic test_reset_mid_eval();
    bit saw_we;
    saw_we = 1'b0;
    pulse(1, 0, 0);
    repeat (3) begin
      if (HIST_WE === 1'b1) saw_we = 1'b1;
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if (STATE !== 3'd0 || HITS !== 3'd0 || BLOWS !== 3'd0 || ROUND !== 4'd0)
      $display("FAIL mid_reset: got st=%0d h=%0d b=%0d r=%0d want 0/0/0/0", STATE, HITS, BLOWS, ROUND);
    else n_pass++;
    repeat (30) begin
      if (HIST_WE === 1'b1) saw_we = 1'b1;
      @(negedge CLK);
    end
    n_checks++;
    if (saw_we || STATE !== 3'd0) $display("FAIL mid_reset_quiet: got we_seen=%0d st=%0d want 0/0", saw_we, STATE);
    else n_pass++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_gen();
    test_exact_win();
    test_duplicates();
    test_loss();
    test_input_wrap();
    test_reset_mid_eval();
    n_checks++;
    if (bad_we !== 0) $display("FAIL hist_we_outside_commit: got %0d cycles want 0", bad_we);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mastermind_round_controller.md
Name: mastermind_round_controller

Overview:
- Game-sequencing FSM for the MasterMind board.
- Consumes single-cycle button pulses from the debounce and negative-edge stage. Holds the secret code and the current guess, then scores each guess iteratively (hits and blows).
- Drives state, selection, round and score fields into the game-state record read by the VGA renderer and segment display. Writes one history entry per committed round.

Parameters:
PEGS, 4, pegs per code (2..4)
COLORS, 6, colours per peg (2..8); peg values 0..COLORS-1
MAX_ROUNDS, 10, guesses allowed (1..16)
LFSR_SEED, 16'hACE1, LFSR value after reset (nonzero)

Ports:
CLK  in  1  system clock (CLK_PLL domain)
RST  in  1  synchronous reset, active-high
BTN_NEXT  in  1  pulse: move selection to next peg
BTN_INC  in  1  pulse: increment colour of selected peg
BTN_OK  in  1  pulse: start / submit / acknowledge
CODE_LOAD  in  1  pulse: force secret from CODE_IN (test/debug)
CODE_IN  in  PEGS*3  forced secret; peg i in bits [3i+2:3i]
STATE  out  3  state encoding (below)
SEL  out  2  selected peg index
GUESS  out  PEGS*3  current guess; same packing as CODE_IN
ROUND  out  4  current round, 0-based
HITS  out  3  exact matches of last scored guess
BLOWS  out  3  colour-only matches of last scored guess
HIST_WE  out  1  one-cycle history write strobe
HIST_ADDR  out  4  history row (= ROUND at commit)
HIST_DATA  out  PEGS*3+6  {BLOWS, HITS, GUESS}
BUSY  out  1  high in GEN, EVAL_EXACT, EVAL_COLOR, COMMIT

Behaviour:
- Reset values: STATE=IDLE, SEL=0, GUESS=0, ROUND=0, HITS=0, BLOWS=0, HIST_WE=0, HIST_ADDR=0, HIST_DATA=0, BUSY=0. Internal secret=0, match flags=0, LFSR=LFSR_SEED. Reset has priority over every other input in every state, including mid-evaluation.
- State encoding: IDLE=0, GEN=1, INPUT=2, EVAL_EXACT=3, EVAL_COLOR=4, COMMIT=5, WIN=6, LOSE=7.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states except during reset.
- Button priority when pulses coincide: OK > INC > NEXT; only one acts per cycle. Buttons are ignored while BUSY=1.
- CODE_LOAD: accepted in IDLE or INPUT only. Loads the secret and has priority over buttons that cycle. In IDLE it also moves to INPUT with ROUND=0, skipping GEN.

State transitions:
- IDLE: OK -> GEN. Clears ROUND, SEL, GUESS, HITS, BLOWS and the peg counter.
- GEN: each cycle, takes LFSR[2:0].
  - If the value is < COLORS, store it to secret[peg counter] and increment the counter.
  - Otherwise reject it and retry next cycle; the counter holds.
  - After peg PEGS-1 is stored -> INPUT.
- INPUT:
  - NEXT: SEL = (SEL+1) mod PEGS.
  - INC: GUESS[SEL] = GUESS[SEL]+1, wrapping COLORS-1 -> 0.
  - OK -> EVAL_EXACT with index 0 and all match flags cleared.
- EVAL_EXACT: PEGS cycles, index i per cycle. If guess[i]==secret[i], set gmatch[i], smatch[i] and increment the hit count. -> EVAL_COLOR (i=0, j=0).
- EVAL_COLOR: PEGS*PEGS cycles, pair (i,j) per cycle, j inner.
  - If !gmatch[i] && !smatch[j] && guess[i]==secret[j], set both flags and increment blows.
  - A flag set at pair (i,j) is visible at pair (i,j+1).
  - After (PEGS-1,PEGS-1) -> COMMIT.
- COMMIT: one cycle.
  - HITS and BLOWS update from the internal counters.
  - HIST_WE=1, HIST_ADDR=ROUND, HIST_DATA={counters, GUESS}.
  - Next state: WIN if hits==PEGS; else LOSE if ROUND==MAX_ROUNDS-1; else INPUT with ROUND+1. GUESS and SEL are kept.
- WIN / LOSE: OK -> IDLE.

Timing and arithmetic:
- Latency from OK in INPUT to HIST_WE is PEGS+PEGS*PEGS+1 cycles: 21 at default.
- HIST_WE is never high outside COMMIT.
- All counter arithmetic is unsigned. Hit and blow counters saturate at PEGS and never wrap.

Decomposition:
- Shared package mm_pkg holds:
  - the state enum e_MM_STATE;
  - peg colour typedef t_PEG (logic [2:0]);
  - history-record struct st_HIST_ENTRY {blows, hits, guess};
  - LFSR tap constant.
- The renderer's game-state record embeds e_MM_STATE.
- One sub-module, mm_lfsr16: free-running LFSR with CLK, RST, Q[15:0] and reset value LFSR_SEED.
- Scoring stays inline in the FSM.

Test Plan:
- Reset and start: RST for 2 cycles -> all outputs 0, STATE=0. OK pulse -> STATE=1 next cycle. Within 32 cycles STATE=2, and the secret contains no peg >=6 (read via forced-compare rounds).
- Exact win: CODE_LOAD with secret {1,2,3,4} in IDLE. Set GUESS to {1,2,3,4} via INC/NEXT, then OK -> HIST_WE exactly 21 cycles later, HITS=4, BLOWS=0, HIST_ADDR=0, STATE=6.
- Duplicate handling: secret {1,1,2,3}, guess {1,2,1,1} -> HITS=1, BLOWS=2, STATE=2, ROUND=1.
- Loss: secret {5,5,5,5}, submit guess {0,0,0,0} ten times -> rounds 0..9 logged (HIST_ADDR 0..9, HITS=0, BLOWS=0). STATE=7 after the 10th commit; next OK -> STATE=0.
- Input wrap and priority: in INPUT, INC 6 times on peg 0 -> GUESS peg 0 returns to 0. NEXT 4 times -> SEL=0. INC+NEXT in the same cycle -> only the increment happens.
- Reset mid-evaluation: assert RST 5 cycles after OK -> next cycle STATE=0 and HITS=BLOWS=0. HIST_WE never pulses.
